// File: rtl/imem_loader.sv
// imem_loader: receives framed bytes on a valid/ready stream, assembles 19-bit
// instruction words and writes them into the instruction memory. The CPU is
// held in reset while a frame is in progress. The outcome of the last frame
// is reported as a done/error level plus a two-bit error code.
module imem_loader #(
   parameter int          ADDR_W  = 5,
   parameter int          DATA_W  = 19,
   parameter int          DEPTH   = 32,
   parameter int          TIMEOUT = 1024,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   words_written
);

   // B2 supplies only the top bits of a word; the rest must be zero.
   localparam int          HI_W  = DATA_W - 16;
   localparam int          TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [8:0]  DEPTH_LIM = 9'(DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   localparam logic [1:0] ERR_FORMAT   = 2'd1;
   localparam logic [1:0] ERR_CHECKSUM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_COUNT, S_D0, S_D1, S_D2, S_WRITE, S_CHK
   } state_t;

   state_t             state, state_next;
   logic [ADDR_W-1:0]  ptr;
   logic [ADDR_W:0]    left;
   logic [7:0]         b0, b1;
   logic [HI_W-1:0]    b2;
   logic [7:0]         checksum;
   logic [TMO_W-1:0]   tcnt;

   logic xfer;
   logic start, fmt_err, chk_ok, chk_bad, tmo;

   assign in_ready  = (state != S_WRITE);
   assign xfer      = in_valid && in_ready;
   assign mem_we    = (state == S_WRITE);
   assign mem_addr  = ptr;
   assign mem_wdata = {b2, b1, b0};
   assign busy      = (state != S_IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state decode plus one-cycle event strobes for the datapath.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_next = state;
      start      = 1'b0;
      fmt_err    = 1'b0;
      chk_ok     = 1'b0;
      chk_bad    = 1'b0;
      tmo        = 1'b0;
      case (state)
         S_IDLE:  if (xfer && in_data == SYNC) begin
                     start      = 1'b1;
                     state_next = S_ADDR;
                  end
         S_ADDR:  if (xfer) begin
                     if (in_data[7:ADDR_W] != '0) fmt_err = 1'b1;
                     else                         state_next = S_COUNT;
                  end
         S_COUNT: if (xfer) begin
                     if (in_data == 8'd0 || {1'b0, in_data} > DEPTH_LIM) fmt_err = 1'b1;
                     else                                                state_next = S_D0;
                  end
         S_D0:    if (xfer) state_next = S_D1;
         S_D1:    if (xfer) state_next = S_D2;
         S_D2:    if (xfer) begin
                     if (in_data[7:HI_W] != '0) fmt_err = 1'b1;
                     else                       state_next = S_WRITE;
                  end
         S_WRITE: state_next = (left == (ADDR_W+1)'(1)) ? S_CHK : S_D0;
         S_CHK:   if (xfer) begin
                     if (in_data == checksum) chk_ok  = 1'b1;
                     else                     chk_bad = 1'b1;
                     state_next = S_IDLE;
                  end
         default: state_next = S_IDLE;
      endcase
      if (fmt_err) state_next = S_IDLE;
      // Inactivity inside a frame; WRITE never consumes a byte so it is exempt.
      if (state != S_IDLE && state != S_WRITE && !xfer && tcnt == TMO_LAST) begin
         tmo        = 1'b1;
         state_next = S_IDLE;
      end
   end

   // Datapath: pointer, word assembly, checksum, status and idle counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr           <= '0;
         left          <= '0;
         b0            <= '0;
         b1            <= '0;
         b2            <= '0;
         checksum      <= '0;
         tcnt          <= '0;
         cpu_hold      <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_code      <= '0;
         words_written <= '0;
      end else begin
         if (start) begin
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= '0;
            words_written <= '0;
            checksum      <= '0;
            cpu_hold      <= 1'b1;
         end

         if (xfer) begin
            case (state)
               S_ADDR:  begin
                           ptr      <= in_data[ADDR_W-1:0];
                           checksum <= checksum ^ in_data;
                        end
               S_COUNT: begin
                           left     <= in_data[ADDR_W:0];
                           checksum <= checksum ^ in_data;
                        end
               S_D0:    begin
                           b0       <= in_data;
                           checksum <= checksum ^ in_data;
                        end
               S_D1:    begin
                           b1       <= in_data;
                           checksum <= checksum ^ in_data;
                        end
               S_D2:    begin
                           b2       <= in_data[HI_W-1:0];
                           checksum <= checksum ^ in_data;
                        end
               default: ;
            endcase
         end

         // DEPTH == 2**ADDR_W, so the natural pointer overflow is the wrap.
         if (state == S_WRITE) begin
            ptr           <= ptr + 1'b1;
            left          <= left - 1'b1;
            words_written <= words_written + 1'b1;
         end

         if (fmt_err) begin
            error    <= 1'b1;
            err_code <= ERR_FORMAT;
            cpu_hold <= 1'b0;
         end
         if (chk_ok) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
         end
         if (chk_bad) begin
            error    <= 1'b1;
            err_code <= ERR_CHECKSUM;
            cpu_hold <= 1'b0;
         end
         if (tmo) begin
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
            cpu_hold <= 1'b0;
         end

         if (state == S_IDLE || xfer) tcnt <= '0;
         else if (state != S_WRITE)   tcnt <= tcnt + 1'b1;
      end
   end

endmodule
